tmr_reg_ctrl: RTL
=================

# tmr_reg_ctrl

APB-slave register controller for the 8-bit timer counter. It holds the timer data (TDR) and control (TCR) registers that configure the counter. It captures the counter's overflow/underflow pulses into sticky status flags and raises a maskable interrupt. It sits between the APB bus and the counter/clock-divider datapath, in the PCLK domain.

## Interface
Parameters:
- ADDR_W, 8, APB address width; only PADDR[2:0] is decoded, upper bits must be 0.

Ports:
- PCLK  in  1  system clock; all state on rising edge
- PRESETn  in  1  asynchronous active-low reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_W  register address
- PWDATA  in  8  write data
- PRDATA  out  8  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  transfer error; valid with PREADY
- TDR  out  8  reload/compare value to counter
- TCR  out  8  control to counter: [7] load, [5] count-down, [4] enable, [1:0] clock select
- TCNT  in  8  live counter value
- over_flow  in  1  counter overflow indication; level, may last several PCLK
- under_flow  in  1  counter underflow indication; level, may last several PCLK
- tmr_int  out  1  registered interrupt

## Operation
- Register map:
  - 0x0 TDR: RW, reset 0x00.
  - 0x1 TCR: RW; bits 6, 3, 2 read 0 and ignore writes; reset 0x00.
  - 0x2 TSR: bit0 OVF, bit1 UNDF; W1C; reset 0x00.
  - 0x3 TCNT: RO mirror of the TCNT input.
  - 0x4 TIER: bit0 OVF interrupt enable, bit1 UNDF interrupt enable; RW; reset 0x00.
- APB FSM states: IDLE → SETUP when PSEL=1 and PENABLE=0. SETUP → ACCESS unconditionally. ACCESS → IDLE when PREADY=1 and PSEL=0. ACCESS → SETUP when PREADY=1 and PSEL=1 (back-to-back transfer). ACCESS stays in ACCESS while PREADY=0.
- A transfer completes only in ACCESS with PSEL, PENABLE and PREADY all 1. PENABLE seen in IDLE is ignored: no write, PREADY=0.
- Error cases:
  - Address 0x5..0x7 or any nonzero PADDR[ADDR_W-1:3]: PSLVERR=1, write discarded, PRDATA=0x00.
  - Write to 0x3: PSLVERR=1, no effect.
- PRDATA shows the selected register during a read access phase and is 0x00 otherwise.
- Flag capture: over_flow and under_flow are registered once (prev). TSR.OVF sets on the cycle where over_flow=1 and prev=0 (rising edge), and the same rule sets UNDF. A single long pulse sets the flag exactly once.
- Set has priority: when a rising edge and a W1C clear of the same bit land in one cycle, the bit ends at 1.
- tmr_int <= |(TSR[1:0] & TIER[1:0]), one-cycle registered.
- TCR.load is a plain software bit. The controller never auto-clears it.

## Timing
- Reset (PRESETn=0, asynchronous): FSM in IDLE. PRDATA=0x00, PREADY=0, PSLVERR=0, TDR=0x00, TCR=0x00, tmr_int=0. TSR, TIER and the edge registers are 0.
- Write latency: TDR/TCR/TIER update on the PCLK edge that completes the transfer and are visible to the counter the next cycle.
- Read data: combinational from the registers during the completing cycle. A TSR read in the same cycle as a flag set returns the pre-set value.
- Flag latency: over_flow rises at edge N (sampled), TSR bit is 1 after edge N, tmr_int=1 after edge N+1.
- Reset asserted mid-transfer aborts it; no register update occurs.

## Configuration
- APB_WAIT_EN:
  - Defined: one wait state on every transfer. PREADY=0 in the first ACCESS cycle and 1 in the second, so each transfer takes 3 cycles. PSLVERR and PRDATA are valid only when PREADY=1.
  - Undefined: PREADY=1 in the first ACCESS cycle, so each transfer takes 2 cycles.

## Test plan
- Reset then read all addresses: TDR/TCR/TSR/TIER read 0x00, TCNT reads the input value, PSLVERR=0.
- Write TDR=0xDF, then TCR=0x90 (reads back 0x90), then TCR=0xFF. Required: TDR output 0xDF after the completing edge, and TCR=0xB3 after the 0xFF write (reserved bits masked).
- TIER=0x01; hold over_flow high for 8 cycles. Required: TSR=0x01 (set once), tmr_int=1 two edges after the rise. Then write TSR=0x01: TSR=0x00 and tmr_int=0 the following cycle.
- Rising edge of under_flow in the same cycle as a W1C write of 0x02 to TSR: TSR.UNDF stays 1.
- Write to 0x3, write to 0x6, read 0x7: each completes with PSLVERR=1; no register changes; read returns 0x00.
- Back-to-back writes with PSEL held high, run with and without APB_WAIT_EN: 2 and 3 cycles per transfer respectively. Assert PRESETn low during an ACCESS cycle: the write is lost and all outputs return to reset values immediately.

Source files
------------

// File: rtl/tmr_reg_ctrl_if.sv
// tmr_reg_ctrl_if: APB bus bundle between the bus master and the timer register controller.
interface tmr_reg_ctrl_if #(parameter int ADDR_W = 8);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [7:0]        PWDATA;
  logic [7:0]        PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
  modport slave (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/tmr_reg_ctrl.sv
// tmr_reg_ctrl: APB register block (TDR/TCR/TSR/TCNT/TIER) for the 8-bit timer with sticky flags and interrupt.
// Define APB_WAIT_EN to insert one wait state into every transfer.
module tmr_reg_ctrl #(parameter int ADDR_W = 8) (
  input  logic          PCLK,
  input  logic          PRESETn,
  tmr_reg_ctrl_if.slave apb,
  output logic [7:0]    TDR,
  output logic [7:0]    TCR,
  input  logic [7:0]    TCNT,
  input  logic          over_flow,
  input  logic          under_flow,
  output logic          tmr_int
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, phase, state_n;
  logic [2:0] sel;
  logic [1:0] tsr, tier, prev, rise, clr;
  logic       bad, done, we;
  logic [7:0] rdata;
  assign sel  = apb.PADDR[2:0];
  assign rise = {under_flow, over_flow} & ~prev;
  // SETUP is resolved in the same cycle the master presents it, so the register only ever holds IDLE or ACCESS
  always_comb begin
    phase   = state;
    state_n = state;
    if (state == IDLE && apb.PSEL && !apb.PENABLE) phase = SETUP;
    state_n = phase == SETUP ? ACCESS : (phase == ACCESS && apb.PREADY) ? IDLE : phase;
  end
`ifdef APB_WAIT_EN
  logic waited;
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) waited <= 1'b0;
    else waited <= phase == ACCESS && !waited;
  assign apb.PREADY = phase == ACCESS && waited;
`else
  assign apb.PREADY = phase == ACCESS;
`endif
  always_comb begin
    bad   = |apb.PADDR[ADDR_W-1:3] || sel > 3'd4 || (apb.PWRITE && sel == 3'd3);
    done  = phase == ACCESS && apb.PSEL && apb.PENABLE && apb.PREADY;
    we    = done && apb.PWRITE && !bad;
    clr   = (we && sel == 3'd2) ? apb.PWDATA[1:0] : 2'b00;
    rdata = bad ? 8'h00 :
            sel == 3'd0 ? TDR :
            sel == 3'd1 ? TCR :
            sel == 3'd2 ? {6'b0, tsr} :
            sel == 3'd3 ? TCNT : {6'b0, tier};
  end
  assign apb.PRDATA  = (done && !apb.PWRITE) ? rdata : 8'h00;
  assign apb.PSLVERR = done && bad;
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      state   <= IDLE;
      TDR     <= 8'h00;
      TCR     <= 8'h00;
      tsr     <= 2'b00;
      tier    <= 2'b00;
      prev    <= 2'b00;
      tmr_int <= 1'b0;
    end else begin
      state   <= state_n;
      prev    <= {under_flow, over_flow};
      tsr     <= (tsr & ~clr) | rise;
      tmr_int <= |(tsr & tier);
      if (we && sel == 3'd0) TDR <= apb.PWDATA;
      if (we && sel == 3'd1) TCR <= apb.PWDATA & 8'hB3;
      if (we && sel == 3'd4) tier <= apb.PWDATA[1:0];
    end
endmodule
